// File: rtl/add_order_if.sv
// Bundles the add_order request/result handshake and its RAM-side bus.
interface add_order_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              start;
  logic              side;
  logic [15:0]       id;
  logic [15:0]       price;
  logic [15:0]       qty;
  logic [ADDR_W-1:0] mem_addr;
  logic [47:0]       mem_wdata;
  logic              buy_we;
  logic              sell_we;
  logic [47:0]       buy_rdata;
  logic [47:0]       sell_rdata;
  logic [15:0]       status;
  logic [ADDR_W-1:0] slot;
  logic              done;

  // Requester plus RAM side: drives requests and read data, observes results.
  modport master (
    output start, side, id, price, qty, buy_rdata, sell_rdata,
    input  mem_addr, mem_wdata, buy_we, sell_we, status, slot, done
  );

  // The add_order engine.
  modport slave (
    input  start, side, id, price, qty, buy_rdata, sell_rdata,
    output mem_addr, mem_wdata, buy_we, sell_we, status, slot, done
  );
endinterface

// File: rtl/add_order.sv
// add_order: scans one side of the order book for a duplicate live ID and
// writes the new order into the lowest-index free slot (deleted or end).
module add_order #(
  parameter int unsigned BOOK_SIZE = 10,
  parameter int unsigned ADDR_W    = 12
) (
  input  logic        clk,
  input  logic        rst,
  add_order_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BOOK_SIZE - 1);
  localparam logic [47:0]       WORD_END = 48'h0;
  localparam logic [47:0]       WORD_DEL = 48'hFFFF_FFFF_FFFF;

  localparam logic [15:0] ST_FULL   = 16'd0;
  localparam logic [15:0] ST_PLACED = 16'd1;
  localparam logic [15:0] ST_INVAL  = 16'd2;
  localparam logic [15:0] ST_DUP    = 16'd3;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT,
    EVAL,
    WRITE,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] free_q, free_d;
  logic              free_found_q, free_found_d;
  logic              side_q, side_d;
  logic [15:0]       id_q, id_d;
  logic [15:0]       price_q, price_d;
  logic [15:0]       qty_q, qty_d;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [47:0]       mem_wdata_q, mem_wdata_d;
  logic              buy_we_q, buy_we_d;
  logic              sell_we_q, sell_we_d;
  logic [15:0]       status_q, status_d;
  logic [ADDR_W-1:0] slot_q, slot_d;
  logic              done_q, done_d;

  logic [47:0]       word;
  logic              scan_on;

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.buy_we    = buy_we_q;
  assign bus.sell_we   = sell_we_q;
  assign bus.status    = status_q;
  assign bus.slot      = slot_q;
  assign bus.done      = done_q;

  // Next-state and next-output logic; write enables default low so they pulse.
  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    free_d       = free_q;
    free_found_d = free_found_q;
    side_d       = side_q;
    id_d         = id_q;
    price_d      = price_q;
    qty_d        = qty_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    buy_we_d     = 1'b0;
    sell_we_d    = 1'b0;
    status_d     = status_q;
    slot_d       = slot_q;
    done_d       = done_q;
    scan_on      = 1'b0;
    word         = side_q ? bus.sell_rdata : bus.buy_rdata;

    unique case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (bus.start) begin
          side_d       = bus.side;
          id_d         = bus.id;
          price_d      = bus.price;
          qty_d        = bus.qty;
          i_d          = '0;
          free_found_d = 1'b0;
          state_d      = CHECK;
        end
      end

      CHECK: begin
        // Rejecting these keeps 48'h0 and all-ones reserved as markers.
        if ((qty_q == 16'd0) || (id_q == 16'hFFFF)) begin
          status_d = ST_INVAL;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        mem_addr_d = i_q;
        state_d    = WAIT;
      end

      WAIT: begin
        state_d = EVAL;
      end

      EVAL: begin
        if (word == WORD_END) begin
          if (!free_found_q) begin
            free_d = i_q;
          end
          state_d = WRITE;
        end else if (word == WORD_DEL) begin
          if (!free_found_q) begin
            free_d       = i_q;
            free_found_d = 1'b1;
          end
          scan_on = 1'b1;
        end else if (word[47:32] == id_q) begin
          status_d = ST_DUP;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          scan_on = 1'b1;
        end

        // A deleted slot at the last index counts as free for this decision.
        if (scan_on) begin
          if (i_q == LAST_IDX) begin
            if (free_found_d) begin
              state_d = WRITE;
            end else begin
              status_d = ST_FULL;
              done_d   = 1'b1;
              state_d  = DONE;
            end
          end else begin
            i_d     = i_q + ADDR_W'(1);
            state_d = ISSUE;
          end
        end
      end

      WRITE: begin
        mem_addr_d  = free_q;
        mem_wdata_d = {id_q, price_q, qty_q};
        buy_we_d    = ~side_q;
        sell_we_d   = side_q;
        slot_d      = free_q;
        status_d    = ST_PLACED;
        done_d      = 1'b1;
        state_d     = DONE;
      end

      DONE: begin
        if (!bus.start) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched request and registered outputs; synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      i_q          <= '0;
      free_q       <= '0;
      free_found_q <= 1'b0;
      side_q       <= 1'b0;
      id_q         <= '0;
      price_q      <= '0;
      qty_q        <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      buy_we_q     <= 1'b0;
      sell_we_q    <= 1'b0;
      status_q     <= '0;
      slot_q       <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      free_q       <= free_d;
      free_found_q <= free_found_d;
      side_q       <= side_d;
      id_q         <= id_d;
      price_q      <= price_d;
      qty_q        <= qty_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      buy_we_q     <= buy_we_d;
      sell_we_q    <= sell_we_d;
      status_q     <= status_d;
      slot_q       <= slot_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_add_order.sv
// Bench for add_order: directed vector table, reset corner cases and
// randomized books checked against a search-based reference model.
module tb_add_order;

  localparam int BOOK = 10;
  localparam logic [47:0] DEL = 48'hFFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  add_order_if #(.ADDR_W(12)) bus ();

  add_order #(.BOOK_SIZE(10), .ADDR_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // RAM model: registered address, combinational q; bench can bulk-load it.
  logic [15:0][47:0] buy_ram, sell_ram, ld_buy, ld_sell;
  logic              load = 1'b0;
  logic [3:0]        addr_q;

  always @(posedge clk) begin
    addr_q <= bus.mem_addr[3:0];
    if (load) begin
      buy_ram  <= ld_buy;
      sell_ram <= ld_sell;
    end else begin
      if (bus.buy_we)  buy_ram[bus.mem_addr[3:0]]  <= bus.mem_wdata;
      if (bus.sell_we) sell_ram[bus.mem_addr[3:0]] <= bus.mem_wdata;
    end
  end

  assign bus.buy_rdata  = buy_ram[addr_q];
  assign bus.sell_rdata = sell_ram[addr_q];

  // Write-enable monitor: pulse counts and pulses longer than one clock.
  int   buy_cnt = 0, sell_cnt = 0, long_we = 0;
  logic prev_b = 1'b0, prev_s = 1'b0;
  always @(negedge clk) begin
    if (bus.buy_we && prev_b)  long_we++;
    if (bus.sell_we && prev_s) long_we++;
    if (bus.buy_we)  buy_cnt++;
    if (bus.sell_we) sell_cnt++;
    prev_b = bus.buy_we;
    prev_s = bus.sell_we;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_ram(input string nm, input logic [15:0][47:0] act,
                         input logic [15:0][47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int k = 0; k < 16; k++) begin
        if (act[k] !== exp[k]) begin
          $display("FAIL %s: word %0d got %0h expected %0h", nm, k, act[k], exp[k]);
          break;
        end
      end
    end
  endtask

  function automatic logic [47:0] mk(input int oid, input int p, input int q);
    return {16'(oid), 16'(p), 16'(q)};
  endfunction

  // Reference: find the terminator, then search the live region before it.
  function automatic void model(input logic [9:0][47:0] img, input logic [15:0] rid,
                                input logic [15:0] rq, output logic [15:0] st,
                                output int sl, output int lat);
    int z, lim, d, fd, n;
    sl = 0;
    if (rq == 16'd0 || rid == 16'hFFFF) begin
      st = 16'd2; lat = 2; return;
    end
    z = BOOK;
    for (int k = BOOK - 1; k >= 0; k--) if (img[k] == 48'h0) z = k;
    lim = z;
    d = -1; fd = -1;
    for (int k = lim - 1; k >= 0; k--) begin
      if (img[k] == DEL) fd = k;
      else if (img[k][47:32] == rid) d = k;
    end
    if (d >= 0) begin
      st = 16'd3; n = d + 1;
    end else begin
      n = (z < BOOK) ? z + 1 : BOOK;
      if (fd >= 0)       begin st = 16'd1; sl = fd; end
      else if (z < BOOK) begin st = 16'd1; sl = z;  end
      else               st = 16'd0;
    end
    lat = 2 + 3 * n + ((st == 16'd1) ? 1 : 0);
  endfunction

  task automatic load_rams(input logic [15:0][47:0] b, input logic [15:0][47:0] s);
    @(negedge clk);
    ld_buy = b; ld_sell = s; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  function automatic logic [15:0][47:0] garbage();
    logic [15:0][47:0] g = '0;
    for (int k = 0; k < BOOK; k++) g[k] = {$urandom, $urandom};
    return g;
  endfunction

  // One insert transaction with full result, latency, write and RAM checks.
  task automatic run_txn(input string nm, input logic sd, input logic [15:0] rid,
                         input logic [15:0] rp, input logic [15:0] rq,
                         input logic [9:0][47:0] img, input int hold,
                         input logic [15:0] est, input int eslot, input int elat);
    logic [15:0][47:0] sel, oth, exp_sel;
    int b0, s0, l0, cyc;
    logic got;
    sel = '0; sel[9:0] = img;
    oth = garbage();
    exp_sel = sel;
    if (est == 16'd1) exp_sel[eslot] = {rid, rp, rq};
    if (sd) load_rams(oth, sel); else load_rams(sel, oth);
    b0 = buy_cnt; s0 = sell_cnt; l0 = long_we;
    @(negedge clk);
    bus.start = 1'b1; bus.side = sd; bus.id = rid; bus.price = rp; bus.qty = rq;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        bus.side = ~sd; bus.id = 16'($urandom); bus.price = 16'($urandom);
        bus.qty = 16'($urandom);
      end
      if (bus.done) got = 1'b1;
    end
    if (!got) begin
      errors++; checks++;
      $display("FAIL %s timeout: done not seen after %0d clk", nm, cyc);
    end else begin
      chk({nm, " status"}, 64'(bus.status), 64'(est));
      if (est == 16'd1) chk({nm, " slot"}, 64'(bus.slot), 64'(eslot));
      chk({nm, " latency"}, 64'(cyc), 64'(elat));
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({nm, " done held"}, 64'(bus.done), 64'd1);
    end
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk({nm, " done falls"}, 64'(bus.done), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, " buy_we pulses"}, 64'(buy_cnt - b0), 64'((!sd && est == 16'd1) ? 1 : 0));
    chk({nm, " sell_we pulses"}, 64'(sell_cnt - s0), 64'((sd && est == 16'd1) ? 1 : 0));
    chk({nm, " we width"}, 64'(long_we - l0), 64'd0);
    if (sd) begin
      chk_ram({nm, " sell ram"}, sell_ram, exp_sel);
      chk_ram({nm, " buy ram"}, buy_ram, oth);
    end else begin
      chk_ram({nm, " buy ram"}, buy_ram, exp_sel);
      chk_ram({nm, " sell ram"}, sell_ram, oth);
    end
  endtask

  // Reset after a fixed number of clocks into a scan of an empty buy book.
  task automatic reset_mid(input string nm, input int clocks);
    int b0, s0;
    load_rams('0, '0);
    b0 = buy_cnt; s0 = sell_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.side = 1'b0; bus.id = 16'd11; bus.price = 16'd1; bus.qty = 16'd1;
    repeat (clocks) @(posedge clk);
    #1;
    rst = 1'b1; bus.start = 1'b0;
    @(posedge clk); #1;
    chk({nm, " outputs"}, {bus.mem_addr, bus.slot, bus.status, bus.mem_wdata[15:0],
         4'(bus.buy_we), 4'(bus.sell_we), 4'(bus.done)}, 64'd0);
    chk({nm, " wdata"}, 64'(bus.mem_wdata), 64'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk({nm, " no write"}, 64'(buy_cnt - b0 + sell_cnt - s0), 64'd0);
    chk_ram({nm, " ram"}, buy_ram, '0);
    chk({nm, " idle"}, 64'(bus.done), 64'd0);
  endtask

  typedef struct {
    string             nm;
    logic              sd;
    logic [15:0]       rid, rp, rq;
    logic [9:0][47:0]  img;
    int                hold;
    logic [15:0]       est;
    int                eslot;
    int                elat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [9:0][47:0] im;
    logic [15:0] st, rid, rq;
    int sl, lat;

    bus.start = 1'b0; bus.side = 1'b0; bus.id = '0; bus.price = '0; bus.qty = '0;
    ld_buy = '0; ld_sell = '0;

    vecs[0] = '{"empty buy", 1'b0, 16'd5, 16'd100, 16'd7, '0, 3, 16'd1, 0, 6};
    im = '0; im[0] = mk(3, 10, 2); im[1] = DEL; im[2] = mk(4, 11, 3);
    vecs[1] = '{"sell reuse del", 1'b1, 16'd9, 16'd50, 16'd8, im, 0, 16'd1, 1, 15};
    vecs[2] = '{"sell dup", 1'b1, 16'd4, 16'd50, 16'd8, im, 1, 16'd3, 0, 11};
    im = '0; for (int k = 0; k < BOOK; k++) im[k] = mk(k + 1, 200 + k, 5);
    vecs[3] = '{"buy full", 1'b0, 16'd20, 16'd1, 16'd1, im, 0, 16'd0, 0, 32};
    vecs[4] = '{"qty zero", 1'b0, 16'd21, 16'd1, 16'd0, im, 0, 16'd2, 0, 2};
    vecs[5] = '{"id ffff", 1'b1, 16'hFFFF, 16'd1, 16'd4, '0, 0, 16'd2, 0, 2};
    im = '0; im[0] = DEL; im[1] = mk(7, 1, 1);
    vecs[6] = '{"dup after del", 1'b0, 16'd7, 16'd2, 16'd2, im, 0, 16'd3, 0, 8};
    for (int k = 0; k < BOOK; k++) im[k] = DEL;
    vecs[7] = '{"all deleted", 1'b1, 16'd8, 16'd3, 16'd3, im, 0, 16'd1, 0, 33};
    for (int k = 0; k < BOOK; k++) im[k] = mk(k + 1, 9, 9);
    im[9] = DEL;
    vecs[8] = '{"last deleted", 1'b0, 16'd50, 16'd4, 16'd6, im, 0, 16'd1, 9, 33};

    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {bus.mem_addr, bus.slot, bus.status, bus.mem_wdata[15:0],
        4'(bus.buy_we), 4'(bus.sell_we), 4'(bus.done)}, 64'd0);
    chk("reset wdata", 64'(bus.mem_wdata), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[v])
      run_txn(vecs[v].nm, vecs[v].sd, vecs[v].rid, vecs[v].rp, vecs[v].rq,
              vecs[v].img, vecs[v].hold, vecs[v].est, vecs[v].eslot, vecs[v].elat);

    reset_mid("rst in wait", 3);
    reset_mid("rst in write", 5);

    for (int t = 0; t < 30; t++) begin
      int z;
      z = $urandom_range(0, BOOK);
      im = '0;
      for (int k = 0; k < BOOK; k++) begin
        if (k < z) im[k] = ($urandom_range(0, 3) == 0) ? DEL
                           : mk($urandom_range(1, 12), $urandom, $urandom_range(1, 65535));
        else if (k > z) im[k] = {$urandom, $urandom};
      end
      rid = 16'($urandom_range(1, 13));
      if ($urandom_range(0, 9) == 0) rid = 16'hFFFF;
      rq = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      model(im, rid, rq, st, sl, lat);
      run_txn($sformatf("rand%0d", t), 1'($urandom), rid, 16'($urandom), rq, im,
              $urandom_range(0, 2), st, sl, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
